lsu: RTL and testbench

- Load/store unit directly downstream of the RV32I datapath.
- Consumes the datapath's ALUResult (address), WriteData and funct3, and drives a request/grant/response data-memory bus.
- Returns formatted load data to the datapath's ReadData input.
- Asserts Stall so the core holds PC and register writes until the access completes. It also handles byte/halfword lanes, sign/zero extension, misalignment and bus timeout.

---
 rtl/lsu_pkg.sv | 33 +++
 rtl/lsu_lane.sv | 64 ++++++
 rtl/lsu.sv | 169 ++++++++++++++++
 tb/tb_lsu.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg -- shared definitions for the load/store unit.
//   * funct3 encodings for RV32I loads and stores
//   * FSM state type
//   * is_misaligned(): alignment fault check for a given access size/offset
package lsu_pkg;

   // Load encodings (stores reuse the size bits: SB=000, SH=001, SW=010)
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   // Size is carried by funct3[1:0]; the unused size code 11 is treated as a word.
   function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
      logic m;
      m = 1'b0;
      case (f3[1:0])
         2'b00:   m = 1'b0;
         2'b01:   m = off[0];
         default: m = |off;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/lsu_lane.sv
// lsu_lane -- combinational byte-lane logic of the load/store unit.
// Store side (from the access being issued):
//   st_funct3, st_off, st_data  -> st_be (byte enables), st_wdata (lane-replicated data)
// Load side (from the access in flight):
//   ld_funct3, ld_off, ld_rdata -> ld_data (selected and sign/zero extended)
module lsu_lane
   import lsu_pkg::*;
(
   input  logic [2:0]  st_funct3,
   input  logic [1:0]  st_off,
   input  logic [31:0] st_data,
   output logic [3:0]  st_be,
   output logic [31:0] st_wdata,
   input  logic [2:0]  ld_funct3,
   input  logic [1:0]  ld_off,
   input  logic [31:0] ld_rdata,
   output logic [31:0] ld_data
);

   logic [7:0]  rd_byte [4];
   logic [7:0]  sel_byte;
   logic [15:0] sel_half;

   // Split the returned word into its four byte lanes.
   for (genvar gi = 0; gi < 4; gi++) begin : g_bytes
      assign rd_byte[gi] = ld_rdata[8*gi +: 8];
   end

   assign sel_byte = rd_byte[ld_off];
   assign sel_half = ld_off[1] ? ld_rdata[31:16] : ld_rdata[15:0];

   // Store lanes: data is replicated across the word so the byte enables alone
   // pick the target lane; the memory ignores disabled lanes.
   always_comb begin
      st_be    = 4'b1111;
      st_wdata = st_data;
      case (st_funct3[1:0])
         2'b00: begin
            st_be    = 4'b0001 << st_off;
            st_wdata = {4{st_data[7:0]}};
         end
         2'b01: begin
            st_be    = 4'b0011 << st_off;
            st_wdata = {2{st_data[15:0]}};
         end
         default: begin
            st_be    = 4'b1111;
            st_wdata = st_data;
         end
      endcase
   end

   always_comb begin
      ld_data = ld_rdata;
      case (ld_funct3)
         F3_B:    ld_data = {{24{sel_byte[7]}}, sel_byte};
         F3_BU:   ld_data = {24'h0, sel_byte};
         F3_H:    ld_data = {{16{sel_half[15]}}, sel_half};
         F3_HU:   ld_data = {16'h0, sel_half};
         default: ld_data = ld_rdata;
      endcase
   end

endmodule

// File: rtl/lsu.sv
// lsu -- load/store unit between the RV32I datapath and a req/gnt/rvalid bus.
// Datapath side:
//   MemRead, MemWrite, funct3, Addr, WriteData (in); ReadData, Stall,
//   Misaligned, BusErr (out)
// Bus side:
//   mem_req, mem_we, mem_addr, mem_be, mem_wdata (out);
//   mem_gnt, mem_rvalid, mem_rdata (in)
// Flow: IDLE -> REQ -> (store) DONE | (load) WAIT -> DONE -> IDLE.
// Each REQ/WAIT phase is bounded by TIMEOUT cycles (TIMEOUT >= 2,
// 2**CNT_W > TIMEOUT); expiry finishes the access with a BusErr pulse.
module lsu
   import lsu_pkg::*;
#(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 5
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [2:0]  funct3,
   input  logic [31:0] Addr,
   input  logic [31:0] WriteData,
   output logic [31:0] ReadData,
   output logic        Stall,
   output logic        Misaligned,
   output logic        BusErr,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic        mem_gnt,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   state_t           state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic             buserr_reg, buserr_next;
   logic [31:0]      rdata_reg, rdata_next;
   logic             we_reg;
   logic [31:0]      addr_reg;
   logic [3:0]       be_reg;
   logic [31:0]      wdata_reg;
   logic [2:0]       f3_reg;
   logic [1:0]       off_reg;

   logic             start;
   logic             access;
   logic             fault;
   logic             expired;
   logic [3:0]       lane_be;
   logic [31:0]      lane_wdata;
   logic [31:0]      lane_ld;

   // Store lanes come from the live inputs (captured at issue); load
   // formatting uses the captured size/offset while the response arrives.
   lsu_lane u_lane (
      .st_funct3 (funct3),
      .st_off    (Addr[1:0]),
      .st_data   (WriteData),
      .st_be     (lane_be),
      .st_wdata  (lane_wdata),
      .ld_funct3 (f3_reg),
      .ld_off    (off_reg),
      .ld_rdata  (mem_rdata),
      .ld_data   (lane_ld)
   );

   assign access  = MemRead | MemWrite;
   assign fault   = is_misaligned(funct3, Addr[1:0]);
   assign expired = (cnt_reg == CNT_LAST);

   always_comb begin
      state_next  = state_reg;
      cnt_next    = cnt_reg;
      buserr_next = 1'b0;
      rdata_next  = rdata_reg;
      start       = 1'b0;
      Stall       = 1'b0;
      Misaligned  = 1'b0;
      mem_req     = 1'b0;
      unique case (state_reg)
         ST_IDLE: begin
            if (access && fault) begin
               // Trap is the core's business: no bus activity, no stall.
               Misaligned = 1'b1;
            end else if (access && !reset) begin
               start      = 1'b1;
               Stall      = 1'b1;
               cnt_next   = '0;
               state_next = ST_REQ;
            end
         end
         ST_REQ: begin
            mem_req = 1'b1;
            Stall   = 1'b1;
            if (mem_gnt) begin
               cnt_next   = '0;
               state_next = we_reg ? ST_DONE : ST_WAIT;
            end else if (expired) begin
               buserr_next = 1'b1;
               rdata_next  = '0;
               state_next  = ST_DONE;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         ST_WAIT: begin
            Stall = 1'b1;
            if (mem_rvalid) begin
               rdata_next = lane_ld;
               state_next = ST_DONE;
            end else if (expired) begin
               buserr_next = 1'b1;
               rdata_next  = '0;
               state_next  = ST_DONE;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         ST_DONE: begin
            // One non-stalled cycle retires the instruction; the next one is
            // only looked at once we are back in IDLE.
            state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg  <= ST_IDLE;
         cnt_reg    <= '0;
         buserr_reg <= 1'b0;
         rdata_reg  <= '0;
         we_reg     <= 1'b0;
         addr_reg   <= '0;
         be_reg     <= '0;
         wdata_reg  <= '0;
         f3_reg     <= '0;
         off_reg    <= '0;
      end else begin
         state_reg  <= state_next;
         cnt_reg    <= cnt_next;
         buserr_reg <= buserr_next;
         rdata_reg  <= rdata_next;
         if (start) begin
            we_reg    <= MemWrite;
            addr_reg  <= {Addr[31:2], 2'b00};
            be_reg    <= MemWrite ? lane_be : 4'b0000;
            wdata_reg <= MemWrite ? lane_wdata : 32'h0;
            f3_reg    <= funct3;
            off_reg   <= Addr[1:0];
         end
      end
   end

   assign mem_we    = we_reg;
   assign mem_addr  = addr_reg;
   assign mem_be    = be_reg;
   assign mem_wdata = wdata_reg;
   assign ReadData  = rdata_reg;
   assign BusErr    = buserr_reg;

endmodule

// File: tb/tb_lsu.sv
module tb_lsu;

   localparam int TIMEOUT = 16;

   logic        clk = 1'b0;
   logic        reset;
   logic        MemRead, MemWrite;
   logic [2:0]  funct3;
   logic [31:0] Addr, WriteData;
   logic [31:0] ReadData;
   logic        Stall, Misaligned, BusErr;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_gnt, mem_rvalid;
   logic [31:0] mem_rdata;

   lsu #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
      .clk        (clk),
      .reset      (reset),
      .MemRead    (MemRead),
      .MemWrite   (MemWrite),
      .funct3     (funct3),
      .Addr       (Addr),
      .WriteData  (WriteData),
      .ReadData   (ReadData),
      .Stall      (Stall),
      .Misaligned (Misaligned),
      .BusErr     (BusErr),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_be     (mem_be),
      .mem_wdata  (mem_wdata),
      .mem_gnt    (mem_gnt),
      .mem_rvalid (mem_rvalid),
      .mem_rdata  (mem_rdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] rdata;
      logic        buserr;
      int          stalls;
      int          reqs;
   } exp_t;

   exp_t        sb[$];
   int          checks   = 0;
   int          failures = 0;
   logic [31:0] last_rd  = 32'h0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, act, exp);
      end
   endtask

   // Reference lane behaviour, written from the bus/ISA definition.
   function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [1:0] o);
      logic [3:0] b;
      if (f3[1:0] == 2'b00)      b = 4'b0001 << o;
      else if (f3[1:0] == 2'b01) b = 4'b0011 << o;
      else                       b = 4'b1111;
      return b;
   endfunction

   function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
      logic [31:0] w;
      if (f3[1:0] == 2'b00)      w = {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
      else if (f3[1:0] == 2'b01) w = {wd[15:0], wd[15:0]};
      else                       w = wd;
      return w;
   endfunction

   function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [1:0] o, input logic [31:0] w);
      logic [31:0] s;
      logic [31:0] r;
      s = w >> (8 * o);
      case (f3)
         3'b000:  r = {{24{s[7]}}, s[7:0]};
         3'b100:  r = {24'h0, s[7:0]};
         3'b001:  r = {{16{s[15]}}, s[15:0]};
         3'b101:  r = {16'h0, s[15:0]};
         default: r = w;
      endcase
      return r;
   endfunction

   // One access from issue to retirement. gdly/rdly are 0-based cycle
   // indices within REQ/WAIT at which gnt/rvalid are given; negative = never.
   task automatic run_acc(input string tag, input logic ld, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input int gdly, input int rdly, input logic [31:0] rword);
      exp_t e, got;
      logic to_req, to_wait, waiting, going_wait, done;
      int   req_cnt, wait_cnt, stalls;
      to_req  = (gdly < 0);
      to_wait = ld && !to_req && (rdly < 0);
      e.buserr = to_req || to_wait;
      e.reqs   = to_req ? TIMEOUT : gdly + 1;
      e.stalls = 1 + e.reqs + ((ld && !to_req) ? (to_wait ? TIMEOUT : rdly + 1) : 0);
      if (e.buserr)  e.rdata = 32'h0;
      else if (ld)   e.rdata = m_load(f3, addr[1:0], rword);
      else           e.rdata = last_rd;
      sb.push_back(e);

      @(negedge clk);
      MemRead   = ld;
      MemWrite  = !ld;
      funct3    = f3;
      Addr      = addr;
      WriteData = wd;
      mem_rdata = rword;
      #1;
      check({tag, "_mis0"}, {31'h0, Misaligned}, 32'h0);
      req_cnt = 0; wait_cnt = 0; stalls = 0; waiting = 0; done = 0;
      for (int c = 0; c < 80 && !done; c++) begin
         if (!Stall) begin
            done = 1;
            got  = sb.pop_front();
            check({tag, "_stalls"}, stalls, got.stalls);
            check({tag, "_reqs"}, req_cnt, got.reqs);
            check({tag, "_rdata"}, ReadData, got.rdata);
            check({tag, "_buserr"}, {31'h0, BusErr}, {31'h0, got.buserr});
            last_rd    = got.rdata;
            MemRead    = 1'b0;
            MemWrite   = 1'b0;
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b0;
            if (got.buserr) begin
               @(negedge clk); #1;
               check({tag, "_buserr_pulse"}, {31'h0, BusErr}, 32'h0);
            end
         end else begin
            stalls++;
            going_wait = 1'b0;
            if (mem_req) begin
               if (req_cnt == 0) begin
                  check({tag, "_addr"}, mem_addr, {addr[31:2], 2'b00});
                  check({tag, "_we"}, {31'h0, mem_we}, {31'h0, !ld});
                  check({tag, "_be"}, {28'h0, mem_be}, ld ? 32'h0 : {28'h0, m_be(f3, addr[1:0])});
                  if (!ld) check({tag, "_wdata"}, mem_wdata, m_wdata(f3, wd));
               end
               mem_gnt = (gdly >= 0) && (req_cnt == gdly);
               going_wait = mem_gnt && ld;
               req_cnt++;
            end else begin
               mem_gnt = 1'b0;
            end
            if (waiting) begin
               mem_rvalid = (rdly >= 0) && (wait_cnt == rdly);
               wait_cnt++;
            end else begin
               mem_rvalid = 1'b0;
            end
            waiting = waiting | going_wait;
            @(negedge clk); #1;
         end
      end
      if (!done) begin
         check({tag, "_completion_bound"}, 32'h0, 32'h1);
         MemRead = 1'b0; MemWrite = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
      end
      $display("txn %s ld=%0b f3=%03b addr=%h stalls=%0d reqs=%0d rdata=%h buserr=%0b",
               tag, ld, f3, addr, stalls, req_cnt, ReadData, BusErr);
   endtask

   task automatic run_mis(input string tag, input logic ld, input logic [2:0] f3, input logic [31:0] addr);
      @(negedge clk);
      MemRead = ld; MemWrite = !ld; funct3 = f3; Addr = addr; WriteData = 32'hFFFF_FFFF;
      #1;
      check({tag, "_mis"}, {31'h0, Misaligned}, 32'h1);
      check({tag, "_stall"}, {31'h0, Stall}, 32'h0);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk); #1;
         check({tag, "_noreq"}, {31'h0, mem_req}, 32'h0);
      end
      MemRead = 1'b0; MemWrite = 1'b0;
      $display("txn %s misaligned addr=%h Misaligned=%0b Stall=%0b", tag, addr, Misaligned, Stall);
   endtask

   initial begin
      reset = 1'b1;
      MemRead = 0; MemWrite = 0; funct3 = 3'b000; Addr = 0; WriteData = 0;
      mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
      repeat (3) @(negedge clk);
      #1;
      check("rst_stall", {31'h0, Stall}, 32'h0);
      check("rst_req", {31'h0, mem_req}, 32'h0);
      check("rst_buserr", {31'h0, BusErr}, 32'h0);
      check("rst_rdata", ReadData, 32'h0);
      check("rst_addr", mem_addr, 32'h0);
      check("rst_be", {28'h0, mem_be}, 32'h0);
      check("rst_wdata", mem_wdata, 32'h0);
      check("rst_we", {31'h0, mem_we}, 32'h0);
      @(negedge clk);
      reset = 1'b0;

      run_acc("sw",  1'b0, 3'b010, 32'h100, 32'hDEAD_BEEF, 1, 0, 32'h0);
      run_acc("sb",  1'b0, 3'b000, 32'h203, 32'h0000_00A5, 0, 0, 32'h0);
      run_acc("sh",  1'b0, 3'b001, 32'h106, 32'h1234_ABCD, 2, 0, 32'h0);
      run_acc("lb",  1'b1, 3'b000, 32'h301, 32'h0, 0, 1, 32'h1234_80FF);
      run_acc("lbu", 1'b1, 3'b100, 32'h301, 32'h0, 0, 1, 32'h1234_80FF);
      run_acc("lhu", 1'b1, 3'b101, 32'h302, 32'h0, 0, 1, 32'h1234_80FF);
      run_acc("lh",  1'b1, 3'b001, 32'h302, 32'h0, 1, 0, 32'h8001_7FFF);
      run_acc("lw",  1'b1, 3'b010, 32'h104, 32'h0, 0, 0, 32'hCAFE_F00D);

      run_mis("mis_lw", 1'b1, 3'b010, 32'h102);
      run_mis("mis_lh", 1'b1, 3'b001, 32'h101);
      run_mis("mis_sw", 1'b0, 3'b010, 32'h201);

      run_acc("to_req",  1'b1, 3'b010, 32'h500, 32'h0, -1, 0, 32'h1111_2222);
      run_acc("lw2",     1'b1, 3'b010, 32'h504, 32'h0, 0, 2, 32'h7654_3210);
      run_acc("to_wait", 1'b1, 3'b010, 32'h508, 32'h0, 3, -1, 32'h1357_9BDF);
      run_acc("to_st",   1'b0, 3'b010, 32'h50C, 32'h0F0F_0F0F, -1, 0, 32'h0);

      for (int i = 0; i < 8; i++) begin
         logic        ld;
         logic [1:0]  sz;
         logic [2:0]  f3;
         logic [1:0]  o;
         ld = 1'($urandom_range(0, 1));
         sz = 2'($urandom_range(0, 2));
         f3 = {ld && (sz != 2'b10) && ($urandom_range(0, 1) == 1), 1'b0, 1'b0} | {1'b0, sz};
         if (sz == 2'b00)      o = 2'($urandom_range(0, 3));
         else if (sz == 2'b01) o = {1'($urandom_range(0, 1)), 1'b0};
         else                  o = 2'b00;
         run_acc($sformatf("rnd%0d", i), ld, f3, 32'h1000 + 32'(4 * i) + {30'h0, o},
                 $urandom, $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
      end

      // Make ReadData non-zero so clearing by reset is observable.
      run_acc("pre_rst", 1'b1, 3'b010, 32'h600, 32'h0, 0, 0, 32'hA5A5_5A5A);

      // Reset in the middle of a load's WAIT phase.
      @(negedge clk);
      MemRead = 1'b1; MemWrite = 1'b0; funct3 = 3'b010; Addr = 32'h400; mem_rdata = 32'hFFFF_FFFF;
      @(negedge clk); #1;
      check("rstw_req_up", {31'h0, mem_req}, 32'h1);
      mem_gnt = 1'b1;
      @(negedge clk); #1;
      mem_gnt = 1'b0;
      check("rstw_wait_stall", {31'h0, Stall}, 32'h1);
      MemRead = 1'b0;
      reset = 1'b1;
      #1;
      check("rstw_req", {31'h0, mem_req}, 32'h0);
      check("rstw_stall", {31'h0, Stall}, 32'h0);
      check("rstw_rdata", ReadData, 32'h0);
      check("rstw_buserr", {31'h0, BusErr}, 32'h0);
      @(negedge clk);
      reset = 1'b0;
      mem_rvalid = 1'b1;
      repeat (2) @(negedge clk);
      mem_rvalid = 1'b0;
      #1;
      check("rstw_late_rvalid_rdata", ReadData, 32'h0);
      check("rstw_late_rvalid_stall", {31'h0, Stall}, 32'h0);
      check("rstw_late_rvalid_req", {31'h0, mem_req}, 32'h0);
      $display("txn rst_wait ReadData=%h Stall=%0b mem_req=%0b", ReadData, Stall, mem_req);

      // Unit still works after the aborted access.
      last_rd = 32'h0;
      run_acc("post_rst", 1'b1, 3'b000, 32'h703, 32'h0, 0, 0, 32'h7F00_0000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_time_limit got=%0d exp=%0d", 1, 0);
      $fatal(1, "time limit");
   end

endmodule
